// File: rtl/crc8_pkg.sv
// Shared constants and types for the CRC-8 frame scheduler and its CRC step.
package crc8_pkg;
  localparam logic [8:0] CRC8_POLY = 9'h131;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int         WORD_W    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/crc8_word_step.sv
// One-word CRC-8 update: remainder of {word ^ {crc_in,24'b0}, 8'b0} mod CRC8_POLY.
module crc8_word_step
  import crc8_pkg::*;
(
  input  logic [7:0]        crc_in,
  input  logic [WORD_W-1:0] word,
  output logic [7:0]        crc_out
);

  logic [WORD_W-1:0] dividend;
  logic [7:0]        rem;
  logic              fb;

  // Shift-register form of the long division; the 8 trailing zero bits are implied.
  always_comb begin
    dividend = word ^ {crc_in, 24'b0};
    rem      = '0;
    fb       = 1'b0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      fb  = rem[7] ^ dividend[i];
      rem = {rem[6:0], 1'b0} ^ (fb ? CRC8_POLY[7:0] : 8'h00);
    end
    crc_out = rem;
  end

endmodule

// File: rtl/crc8_frame_sched.sv
// Round-robin packet scheduler sharing one CRC-8 engine across NUM_REQ word streams.
//   state | meaning
//   IDLE  | arbitrate among req_valid from rr_ptr, latch grant, clear crc/cnt
//   BUSY  | stream granted requester's words until a true or forced last beat
module crc8_frame_sched
  import crc8_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [32*NUM_REQ-1:0]      req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic [7:0]                 out_crc,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_err
);

  localparam int SRC_W = $clog2(NUM_REQ);

  state_t            state, state_nxt;
  logic [SRC_W-1:0]  rr_ptr, grant, pick, grant_inc;
  logic [7:0]        crc_acc, crc_next;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic [WORD_W-1:0] word;
  logic              ready_g, accept, beat_last, hit_max, found;

  assign word      = req_data[WORD_W*grant +: WORD_W];
  assign cnt_inc   = cnt + CNT_W'(1);
  assign hit_max   = (cnt_inc == CNT_W'(MAX_LEN));
  assign beat_last = req_last[grant] || hit_max;
  assign grant_inc = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + SRC_W'(1);
  assign ready_g   = !out_valid || out_ready;

  crc8_word_step u_step (
    .crc_in (crc_acc),
    .word   (word),
    .crc_out(crc_next)
  );

  // First requesting index at or after rr_ptr, wrapping.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        pick  = SRC_W'((int'(rr_ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: if (|req_valid) state_nxt = BUSY;
      BUSY: begin
        req_ready[grant] = ready_g;
        accept           = req_valid[grant] && ready_g;
        if (accept && beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      crc_acc   <= CRC8_INIT;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_crc   <= '0;
      out_src   <= '0;
      out_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req_valid) begin
        grant   <= pick;
        crc_acc <= CRC8_INIT;
        cnt     <= '0;
      end
      if (accept) begin
        crc_acc   <= crc_next;
        cnt       <= cnt_inc;
        out_valid <= 1'b1;
        out_data  <= word;
        out_crc   <= crc_next;
        out_src   <= grant;
        out_last  <= beat_last;
        out_err   <= !req_last[grant] && hit_max;
        if (beat_last) rr_ptr <= grant_inc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc8_frame_sched.sv
// Scoreboard bench for crc8_frame_sched: per-requester source queues, byte-wise CRC model.
module tb_crc8_frame_sched;
  localparam int N  = 4;
  localparam int ML = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_last;
  logic [32*N-1:0] req_data;
  logic            out_valid, out_ready, out_last, out_err;
  logic [31:0]     out_data;
  logic [7:0]      out_crc;
  logic [1:0]      out_src;

  always #5 clk = ~clk;

  crc8_frame_sched #(.NUM_REQ(N), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_crc(out_crc), .out_src(out_src), .out_err(out_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [7:0]  crc;
    logic [1:0]  src;
    logic        err;
  } beat_t;

  beat_t       sb[$];
  logic [32:0] srcq[N][$];
  logic [7:0]  m_crc[N];
  int          m_cnt[N];
  int          checks = 0, failures = 0, cyc = 0;
  logic        ready_on = 1'b1;
  logic [N-1:0] fired;
  beat_t       snap;
  logic        s_valid;
  int          src_seen[$];
  int          pop_cyc[$];
  int          n_last = 0, n_err = 0;
  logic [7:0]  last_crc;

  // Byte-at-a-time MSB-first CRC-8, poly x^8+x^5+x^4+1.
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [31:0] w);
    logic [7:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ w[8*b +: 8];
      for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h31) : (r << 1);
    end
    return r;
  endfunction

  function automatic bit pending();
    bit p;
    p = (sb.size() > 0) || s_valid;
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      m_crc[i] = 8'h00;
      m_cnt[i] = 0;
    end
  endtask

  task automatic step();
    beat_t e, got;
    logic [32:0] w;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[32*i +: 32] = srcq[i][0][31:0];
        req_last[i] = srcq[i][0][32];
      end else begin
        req_valid[i] = 1'b0;
        req_data[32*i +: 32] = '0;
        req_last[i] = 1'b0;
      end
    end
    out_ready = ready_on;
    #1;
    snap    = {out_data, out_last, out_crc, out_src, out_err};
    s_valid = out_valid;
    got     = snap;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got data=%h src=%0d, expected no beat", out_data, out_src);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL beat got data=%h last=%b crc=%h src=%0d err=%b expected data=%h last=%b crc=%h src=%0d err=%b",
                   got.data, got.last, got.crc, got.src, got.err, e.data, e.last, e.crc, e.src, e.err);
        end
      end
      src_seen.push_back(int'(out_src));
      pop_cyc.push_back(cyc);
      if (out_last) begin
        n_last++;
        last_crc = out_crc;
        if (out_err) n_err++;
      end
    end
    fired = req_valid & req_ready;
    if (fired != '0) begin
      checks++;
      if ($countones(fired) != 1) begin
        failures++;
        $display("FAIL one_accept got fired=%b expected one-hot", fired);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        w = srcq[i].pop_front();
        m_cnt[i]++;
        m_crc[i] = crc_model(m_crc[i], w[31:0]);
        e.data = w[31:0];
        e.crc  = m_crc[i];
        e.src  = 2'(i);
        e.last = w[32] || (m_cnt[i] == ML);
        e.err  = !w[32] && (m_cnt[i] == ML);
        sb.push_back(e);
        if (e.last) begin
          m_cnt[i] = 0;
          m_crc[i] = 8'h00;
        end
      end
    end
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while (pending() && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (pending()) begin
      failures++;
      $display("FAIL timeout got pending after %0d cycles, expected drained", max_cyc);
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    req_last = '0;
    req_data = '1;
    out_ready = 1'b1;
    clear_model();
    #12;
    checks++;
    if ({out_valid, out_last, out_err, out_data, out_crc, out_src} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b l=%b e=%b d=%h c=%h s=%0d expected all 0",
               out_valid, out_last, out_err, out_data, out_crc, out_src);
    end
    checks++;
    if (req_ready !== '0) begin
      failures++;
      $display("FAIL reset_ready got %b expected 0000", req_ready);
    end
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    srcq[0].push_back({1'b1, 32'h0000_0001});
    n = 0;
    do begin step(); n++; end while (!fired[0] && n < 20);
    step();
    checks++;
    if (!s_valid || snap !== {32'h0000_0001, 1'b1, 8'h31, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL single_latency got v=%b data=%h last=%b crc=%h src=%0d err=%b expected v=1 data=00000001 last=1 crc=31 src=0 err=0",
               s_valid, snap.data, snap.last, snap.crc, snap.src, snap.err);
    end
    run_until_idle(50);
  endtask

  task automatic test_two_word();
    srcq[1].push_back({1'b0, 32'h0000_0001});
    srcq[1].push_back({1'b1, 32'h0000_0000});
    run_until_idle(50);
    checks++;
    if (last_crc !== 8'hD3) begin
      failures++;
      $display("FAIL two_word_crc got %h expected d3", last_crc);
    end
    srcq[1].push_back({1'b0, 32'h0000_0000});
    srcq[1].push_back({1'b1, 32'h0000_0001});
    run_until_idle(50);
    checks++;
    if (last_crc !== 8'h31) begin
      failures++;
      $display("FAIL two_word_swap_crc got %h expected 31", last_crc);
    end
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 32'hA000_0000 + 32'(16*p + i)});
    base = src_seen.size();
    run_until_idle(100);
    for (int k = 0; k < 2*N; k++) begin
      checks++;
      if (src_seen.size() <= base + k || src_seen[base+k] != k % N) begin
        failures++;
        $display("FAIL rr_order beat %0d got src=%0d expected %0d", k,
                 (src_seen.size() > base + k) ? src_seen[base+k] : -1, k % N);
      end
    end
    for (int k = 0; k + 1 < 2*N && base + k + 1 < pop_cyc.size(); k++) begin
      checks++;
      if (pop_cyc[base+k+1] - pop_cyc[base+k] != 2) begin
        failures++;
        $display("FAIL rr_gap beat %0d got spacing=%0d expected 2", k, pop_cyc[base+k+1] - pop_cyc[base+k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n, base;
    beat_t hold;
    ready_on = 1'b0;
    for (int k = 0; k < 4; k++) srcq[2].push_back({(k == 3), 32'h5A5A_0000 + 32'(k)});
    base = src_seen.size();
    n = 0;
    do begin step(); n++; end while (!s_valid && n < 20);
    hold = snap;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (!s_valid || snap !== hold) begin
        failures++;
        $display("FAIL stall_hold cycle %0d got v=%b data=%h crc=%h expected v=1 data=%h crc=%h",
                 k, s_valid, snap.data, snap.crc, hold.data, hold.crc);
      end
      checks++;
      if (req_ready[2] !== 1'b0 || fired !== '0) begin
        failures++;
        $display("FAIL stall_ready cycle %0d got ready=%b fired=%b expected 0", k, req_ready[2], fired);
      end
    end
    ready_on = 1'b1;
    run_until_idle(50);
    checks++;
    if (src_seen.size() - base != 4) begin
      failures++;
      $display("FAIL stall_count got %0d beats expected 4", src_seen.size() - base);
    end
  endtask

  task automatic test_truncate();
    logic [7:0] c;
    logic [31:0] w;
    n_last = 0;
    n_err = 0;
    c = 8'h00;
    for (int k = 0; k < 20; k++) begin
      w = 32'h1357_0000 + 32'(k * 32'h0101);
      srcq[3].push_back({(k == 19), w});
      if (k >= 16) c = crc_model(c, w);
    end
    run_until_idle(100);
    checks++;
    if (n_last != 2 || n_err != 1) begin
      failures++;
      $display("FAIL truncate_lasts got last=%0d err=%0d expected last=2 err=1", n_last, n_err);
    end
    checks++;
    if (last_crc !== c) begin
      failures++;
      $display("FAIL truncate_restart_crc got %h expected %h", last_crc, c);
    end
  endtask

  task automatic test_reset_mid();
    int n, base;
    for (int k = 0; k < 6; k++) srcq[0].push_back({(k == 5), 32'hC0DE_0000 + 32'(k)});
    base = src_seen.size();
    n = 0;
    while (src_seen.size() < base + 2 && n < 50) begin step(); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_mid got out_valid=%b req_ready=%b expected 0 and 0000", out_valid, req_ready);
    end
    clear_model();
    repeat (2) step();
    rst_n = 1'b1;
    srcq[3].push_back({1'b1, 32'hDDDD_0003});
    srcq[1].push_back({1'b1, 32'hBBBB_0001});
    base = src_seen.size();
    run_until_idle(50);
    checks++;
    if (src_seen.size() <= base || src_seen[base] != 1) begin
      failures++;
      $display("FAIL reset_first_grant got src=%0d expected 1",
               (src_seen.size() > base) ? src_seen[base] : -1);
    end
  endtask

  initial begin
    s_valid = 1'b0;
    fired = '0;
    last_crc = 8'h00;
    test_reset();
    test_single();
    test_two_word();
    test_round_robin();
    test_backpressure();
    test_truncate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
